// File: rtl/exe_sequencer.sv
// Program-memory driven initiator for the EXE command interface: fetch, decode,
// issue one instruction, hold it for EXE_LAT cycles, then sample EXE flags.
module exe_sequencer #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int EXE_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rsn,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [15:0]       i_wr_instr,
    input  logic              i_start,
    input  logic [3:0]        i_flag,
    output logic [2:0]        o_oper,
    output logic [3:0]        o_reg0,
    output logic [3:0]        o_reg1,
    output logic [3:0]        o_reg2,
    output logic signed [5:0] o_data,
    output logic              o_imm,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic [AW-1:0]     o_pc,
    output logic [AW:0]       o_count,
    output logic [3:0]        o_flag_last,
    output logic [3:0]        o_flag_acc
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DONE
    } state_t;

    localparam logic [2:0]      OP_HALT   = 3'b111;
    localparam int              WCW       = (EXE_LAT > 1) ? $clog2(EXE_LAT) : 1;
    localparam logic [WCW-1:0]  WAIT_LAST = WCW'(EXE_LAT - 1);
    localparam logic [AW-1:0]   PC_LAST   = AW'(DEPTH - 1);

    state_t         state;
    logic [15:0]    mem [DEPTH];
    logic [15:0]    ir;
    logic [WCW-1:0] wait_cnt;

    // Program memory has no reset so a loaded program survives i_rsn.
    always_ff @(posedge i_clk) begin
        if (state == S_IDLE && i_wr_en)
            mem[i_wr_addr] <= i_wr_instr;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rsn) begin
            state       <= S_IDLE;
            ir          <= '0;
            wait_cnt    <= '0;
            o_oper      <= '0;
            o_reg0      <= '0;
            o_reg1      <= '0;
            o_reg2      <= '0;
            o_data      <= '0;
            o_imm       <= 1'b0;
            o_valid     <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_pc        <= '0;
            o_count     <= '0;
            o_flag_last <= '0;
            o_flag_acc  <= '0;
        end else begin
            o_valid <= 1'b0;
            o_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        o_pc       <= '0;
                        o_count    <= '0;
                        o_flag_acc <= '0;
                        o_busy     <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ir    <= mem[o_pc];
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    if (ir[15:13] == OP_HALT) begin
                        o_done <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        o_oper  <= ir[15:13];
                        o_imm   <= ir[12];
                        o_reg2  <= ir[11:8];
                        o_reg0  <= ir[12] ? 4'd0 : ir[7:4];
                        o_reg1  <= ir[12] ? 4'd0 : ir[3:0];
                        o_data  <= ir[12] ? $signed(ir[5:0]) : 6'sd0;
                        o_valid <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        o_flag_last <= i_flag;
                        o_flag_acc  <= o_flag_acc | i_flag;
                        o_count     <= o_count + (AW+1)'(1);
                        // Return the command bus to the discard command so EXE
                        // never re-executes a stale instruction.
                        o_oper      <= '0;
                        o_imm       <= 1'b0;
                        o_reg0      <= '0;
                        o_reg1      <= '0;
                        o_reg2      <= '0;
                        o_data      <= '0;
                        if (o_pc == PC_LAST) begin
                            o_done <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            o_pc  <= o_pc + AW'(1);
                            state <= S_FETCH;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                S_DONE: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
